error_monitor: RTL and testbench
================================

// Module: error_monitor
// PURPOSE
// Irrigation-controller fault supervisor; sits directly upstream of the 7-segment error decoder.
// Watches tank level sensors, fill pump and irrigation valve, and debounces four fault conditions.
// Latches the highest-priority fault and drives En/C1/C0 to the decoder.
// Asserts inhibit to force actuators off until the operator acknowledges a cleared fault.
// PARAMETERS
// DEB_CYCLES     16    consecutive clk cycles a raw condition must hold before it counts (>=1)
// TIMEOUT_TICKS  600   tick pulses valve_on may stay high before a valve-timeout fault (>=1)
// PORTS
// clk        in   1  system clock, rising edge
// reset_n    in   1  asynchronous active-low reset
// tick       in   1  1-cycle time-base strobe (e.g. 1 Hz), used only by the valve timer
// sens_h     in   1  tank level HIGH sensor, 1 = water present
// sens_m     in   1  tank level MID sensor
// sens_l     in   1  tank level LOW sensor
// fill_on    in   1  inlet/fill pump currently commanded on
// valve_on   in   1  irrigation valve currently commanded on
// ack        in   1  operator acknowledge, synchronous 1-cycle pulse
// En         out  1  error display enable to decoder, 1 = fault latched
// C1         out  1  error code bit 1
// C0         out  1  error code bit 0
// inhibit    out  1  1 = force fill pump and valve off
// BEHAVIOUR
// Reset (reset_n=0, async): state NORMAL, all counters 0, En=0, {C1,C0}=00, inhibit=0.
// All outputs are registered; there is no combinational path from inputs to outputs.
// Raw conditions and codes, in priority order (highest first):
// - 00 SENSOR: (sens_h & ~sens_m) | (sens_h & ~sens_l) | (sens_m & ~sens_l)
// - 11 OVERFLOW: sens_h & fill_on
// - 01 DRY_RUN: ~sens_l & valve_on
// - 10 TIMEOUT: vt_cnt == TIMEOUT_TICKS
// Valve timer vt_cnt:
// - cleared on any edge where valve_on=0
// - otherwise incremented when tick=1
// - saturates at TIMEOUT_TICKS
// Debounce, per condition:
// - counter increments on each edge where raw=1, saturates at DEB_CYCLES, returns to 0 on any edge where raw=0
// - deb = (cnt == DEB_CYCLES)
// Fault latency: raw held continuously -> En=1 on the (DEB_CYCLES+1)th rising edge that samples raw=1.
// FSM:
// - NORMAL: En=0, inhibit=0. If any deb=1, go to FAULT on the same edge and latch the highest-priority code.
// - FAULT: En=1, inhibit=1, code frozen; later or lower-priority faults do not overwrite it.
//   - ack=1 and deb of latched code = 0 -> NORMAL (En, inhibit drop next edge).
//   - ack=1 while latched deb = 1 -> ignored; the operator must re-ack once clear.
// - Ack and a new deb on the same edge out of FAULT: go to NORMAL; the new fault latches on the following edge.
// - ack in NORMAL: no effect.
// - {C1,C0} holds the last latched code after clearing; the decoder blanks on En=0.
// - reset_n mid-FAULT: immediate return to reset values; all debounce history lost.
// Width rules: debounce counters $clog2(DEB_CYCLES+1) bits; vt_cnt $clog2(TIMEOUT_TICKS+1) bits; unsigned, no wrap.
// STRUCTURE
// Shared package rega_pkg:
// - localparams ERR_SENSOR=2'b00, ERR_DRYRUN=2'b01, ERR_TIMEOUT=2'b10, ERR_OVERFLOW=2'b11
// - FSM state encoding: NORMAL=1'b0, FAULT=1'b1
// Sub-module cond_debounce #(DEB_CYCLES) (clk, reset_n, raw, deb), instantiated 4x.
// The valve timer, priority encoder and FSM live in error_monitor itself.
// TESTING (bench uses DEB_CYCLES=4, TIMEOUT_TICKS=3)
// 1. reset_n=0 then release, all sensors 1, pumps off, 50 cycles -> En=0, {C1,C0}=00, inhibit=0 throughout.
// 2. sens_l=0, valve_on=1 held -> En=1, code 01, inhibit=1 on the 5th edge. Raw dropped after 3 cycles -> no fault.
// 3. valve_on=1, sensors full, 3 ticks -> timeout deb 4 cycles after the 3rd tick; En=1, code 10. valve_on=0 + ack -> En=0 next edge.
// 4. sens_h=1 & sens_m=0 & fill_on=1 simultaneously -> code 00 (SENSOR beats OVERFLOW). Ack while raw still true -> stays FAULT.
// 5. FAULT code 01, then OVERFLOW raised -> code stays 01. Ack once dry-run cleared -> NORMAL, then code 11 one edge later.
// 6. reset_n pulsed low mid-FAULT -> outputs 0 asynchronously. After release, a fault needs the full 5 edges again.

Source files
------------

// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation fault supervisor: error codes,
// supervisor state encoding and the fault priority encoder.
package rega_pkg;

   localparam logic [1:0] ERR_SENSOR   = 2'b00;
   localparam logic [1:0] ERR_DRYRUN   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_OVERFLOW = 2'b11;

   typedef enum logic {
      NORMAL = 1'b0,
      FAULT  = 1'b1
   } state_t;

   // deb is indexed by error code; priority is SENSOR > OVERFLOW > DRYRUN > TIMEOUT.
   function automatic logic [1:0] prio_code(input logic [3:0] deb);
      logic [1:0] code;
      code = ERR_TIMEOUT;
      if (deb[ERR_SENSOR])
         code = ERR_SENSOR;
      else if (deb[ERR_OVERFLOW])
         code = ERR_OVERFLOW;
      else if (deb[ERR_DRYRUN])
         code = ERR_DRYRUN;
      return code;
   endfunction

endpackage

// File: rtl/cond_debounce.sv
// Saturating run-length debouncer: deb is high once raw has been sampled
// high on DEB_CYCLES consecutive edges, and drops on the first low sample.
module cond_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic deb
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (!raw)
         cnt <= '0;
      else if (cnt != CNT_MAX)
         cnt <= cnt + 1'b1;
   end

   assign deb = (cnt == CNT_MAX);

endmodule

// File: rtl/error_monitor.sv
// Irrigation fault supervisor: debounces four fault conditions, latches the
// highest-priority one for the 7-segment decoder and inhibits the actuators.
module error_monitor
   import rega_pkg::*;
#(
   parameter int DEB_CYCLES    = 16,
   parameter int TIMEOUT_TICKS = 600
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic sens_h,
   input  logic sens_m,
   input  logic sens_l,
   input  logic fill_on,
   input  logic valve_on,
   input  logic ack,
   output logic En,
   output logic C1,
   output logic C0,
   output logic inhibit
);

   localparam int VT_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [VT_W-1:0] VT_MAX = VT_W'(TIMEOUT_TICKS);

   logic [VT_W-1:0] vt_cnt;
   logic [3:0]      raw;
   logic [3:0]      deb;
   state_t          state_q, state_d;
   logic [1:0]      code_q, code_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         vt_cnt <= '0;
      else if (!valve_on)
         vt_cnt <= '0;
      else if (tick && (vt_cnt != VT_MAX))
         vt_cnt <= vt_cnt + 1'b1;
   end

   // raw and deb are indexed by error code so the latched code selects its own deb bit.
   always_comb begin
      raw               = '0;
      raw[ERR_SENSOR]   = (sens_h & ~sens_m) | (sens_h & ~sens_l) | (sens_m & ~sens_l);
      raw[ERR_OVERFLOW] = sens_h & fill_on;
      raw[ERR_DRYRUN]   = ~sens_l & valve_on;
      raw[ERR_TIMEOUT]  = (vt_cnt == VT_MAX);
   end

   for (genvar g = 0; g < 4; g++) begin : g_deb
      cond_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clk    (clk),
         .reset_n(reset_n),
         .raw    (raw[g]),
         .deb    (deb[g])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= NORMAL;
         code_q  <= ERR_SENSOR;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
      end
   end

   // Leaving FAULT only looks at the latched condition; a new fault latches from NORMAL next edge.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      case (state_q)
         NORMAL: begin
            if (|deb) begin
               state_d = FAULT;
               code_d  = prio_code(deb);
            end
         end
         FAULT: begin
            if (ack && !deb[code_q])
               state_d = NORMAL;
         end
         default: state_d = NORMAL;
      endcase
   end

   assign En      = (state_q == FAULT);
   assign inhibit = (state_q == FAULT);
   assign C1      = code_q[1];
   assign C0      = code_q[0];

endmodule

// File: tb/tb_error_monitor.sv
// Directed bench for error_monitor with DEB_CYCLES=4, TIMEOUT_TICKS=3.
// Observed word is {En, C1, C0, inhibit}.
module tb_error_monitor;

   logic clk;
   logic reset_n;
   logic tick, sens_h, sens_m, sens_l, fill_on, valve_on, ack;
   logic En, C1, C0, inhibit;

   int checks   = 0;
   int failures = 0;

   error_monitor #(
      .DEB_CYCLES   (4),
      .TIMEOUT_TICKS(3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .sens_h  (sens_h),
      .sens_m  (sens_m),
      .sens_l  (sens_l),
      .fill_on (fill_on),
      .valve_on(valve_on),
      .ack     (ack),
      .En      (En),
      .C1      (C1),
      .C0      (C0),
      .inhibit (inhibit)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] outs();
      return {En, C1, C0, inhibit};
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic h, input logic m, input logic l,
                         input logic f, input logic v);
      sens_h   = h;
      sens_m   = m;
      sens_l   = l;
      fill_on  = f;
      valve_on = v;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      tick    = 1'b0;
      ack     = 1'b0;
      set_in(1, 1, 1, 0, 0);
      #1;
      check("reset_state", outs(), 4'b0000);
      step();
      step();
      reset_n = 1'b1;

      // 1: healthy tank, nothing latches; ack in NORMAL has no effect
      for (int i = 0; i < 50; i++) begin
         step();
         check("idle", outs(), 4'b0000);
      end
      pulse_ack();
      check("ack_in_normal", outs(), 4'b0000);

      // 2: dry run latches on 5th edge
      set_in(0, 0, 0, 0, 1);
      for (int i = 1; i <= 4; i++) begin
         step();
         check("dry_pre", outs(), 4'b0000);
      end
      step();
      check("dry_fault", outs(), 4'b1011);
      valve_on = 1'b0;
      step();
      check("dry_hold", outs(), 4'b1011);
      pulse_ack();
      check("dry_clear", outs(), 4'b0010);
      // glitch of 3 cycles must not latch
      valve_on = 1'b1;
      for (int i = 0; i < 3; i++) step();
      valve_on = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("dry_glitch", outs(), 4'b0010);
      end

      // 3: valve timeout after 3 ticks plus debounce
      set_in(1, 1, 1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         if (i < 2) step();
      end
      for (int i = 1; i <= 4; i++) begin
         step();
         check("tmo_pre", outs(), 4'b0010);
      end
      step();
      check("tmo_fault", outs(), 4'b1101);
      valve_on = 1'b0;
      step();
      step();
      check("tmo_hold", outs(), 4'b1101);
      pulse_ack();
      check("tmo_clear", outs(), 4'b0100);

      // 4: sensor beats overflow; ack while still raw is ignored
      set_in(1, 0, 1, 1, 0);
      for (int i = 1; i <= 4; i++) begin
         step();
         check("sens_pre", outs(), 4'b0100);
      end
      step();
      check("sens_fault", outs(), 4'b1001);
      pulse_ack();
      check("sens_ack_ignored", outs(), 4'b1001);
      set_in(1, 1, 1, 0, 0);
      step();
      step();
      pulse_ack();
      check("sens_clear", outs(), 4'b0000);

      // 5: overflow during dry-run fault does not overwrite; latches after ack
      set_in(0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step();
      check("dry2_fault", outs(), 4'b1011);
      set_in(1, 1, 1, 1, 0);
      for (int i = 0; i < 6; i++) begin
         step();
         check("ovf_frozen", outs(), 4'b1011);
      end
      pulse_ack();
      check("dry2_clear", outs(), 4'b0010);
      step();
      check("ovf_fault", outs(), 4'b1111);
      fill_on = 1'b0;
      step();
      step();
      pulse_ack();
      check("ovf_clear", outs(), 4'b0110);

      // 6: asynchronous reset mid-fault, full debounce needed afterwards
      set_in(0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step();
      check("dry3_fault", outs(), 4'b1011);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset", outs(), 4'b0000);
      step();
      check("reset_held", outs(), 4'b0000);
      reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("post_reset_pre", outs(), 4'b0000);
      end
      step();
      check("post_reset_fault", outs(), 4'b1011);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
